// File: rtl/dlis_branch_decider_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : dlis_branch_decider_pkg                                         |
// | Purpose  : Shared sizes, literal/clause/formula types, FSM state type and  |
// |            the literal-to-counter index helper for the DLIS decider.       |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
package dlis_branch_decider_pkg;

  localparam int VAR_W       = 3;   // variable id width, var 0 reserved as padding
  localparam int MAX_LITS    = 5;
  localparam int MAX_CLAUSES = 10;
  localparam int NCL_W       = 4;
  localparam int LEN_W       = 3;
  localparam int NUM_VARS    = (1 << VAR_W) - 1;
  localparam int NUM_LITS    = 2 * NUM_VARS;
  localparam int LIDX_W      = $clog2(NUM_LITS);
  localparam int CNT_W       = $clog2(MAX_CLAUSES * MAX_LITS + 1);

  typedef struct packed {
    logic [VAR_W-1:0] vid;
    logic             pol;  // 1 = positive literal
  } lit_t;

  typedef struct packed {
    lit_t [MAX_LITS-1:0] lits;
    logic [LEN_W-1:0]    len;
  } clause_t;

  typedef struct packed {
    clause_t [MAX_CLAUSES-1:0] clauses;
    logic [NCL_W-1:0]          num_clauses;
  } formula_t;

  typedef logic [CNT_W-1:0] cnt_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_PICK = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  localparam lit_t ZERO_LIT = '0;

  // Counter slot order is +1,-1,+2,-2,...: a lower slot index is exactly the
  // preferred literal on a tie, so the argmax only has to keep the first max.
  function automatic logic [LIDX_W-1:0] lit_index(input lit_t l);
    logic [VAR_W-1:0] v;
    v = l.vid - VAR_W'(1);
    return {v, ~l.pol};
  endfunction

endpackage
`default_nettype wire

// File: rtl/dlis_branch_decider_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : dlis_branch_decider_if                                          |
// | Purpose  : Request/response bundle between solver control and the decider.|
// |   find       : decision request level (master -> slave)                    |
// |   in_formula : CNF formula to scan      (master -> slave)                  |
// |   ended      : decision valid           (slave -> master)                  |
// |   lit_out    : chosen literal           (slave -> master)                  |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
interface dlis_branch_decider_if;
  import dlis_branch_decider_pkg::*;

  logic     find;
  formula_t in_formula;
  logic     ended;
  lit_t     lit_out;

  modport master (output find, output in_formula, input ended, input lit_out);
  modport slave  (input find, input in_formula, output ended, output lit_out);

endinterface
`default_nettype wire

// File: rtl/dlis_branch_decider_argmax.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : db_argmax                                                       |
// | Purpose  : Combinational max finder over the 14 literal counters.          |
// |            Ties go to the lowest variable, then positive before negative.  |
// |            All-zero counters yield the zero literal.                       |
// | Ports    : cnt (in, 14 counters), lit (out, chosen literal)                |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module db_argmax
  import dlis_branch_decider_pkg::*;
(
  input  cnt_t [NUM_LITS-1:0] cnt,
  output lit_t                lit
);

  cnt_t              best;
  logic [LIDX_W-1:0] best_idx;

  always_comb begin
    best     = '0;
    best_idx = '0;
    // Strict compare keeps the first (most preferred) slot on equal counts.
    for (int i = 0; i < NUM_LITS; i++) begin
      if (cnt[i] > best) begin
        best     = cnt[i];
        best_idx = LIDX_W'(i);
      end
    end
    lit = ZERO_LIT;
    if (best != '0) begin
      lit.vid = best_idx[LIDX_W-1:1] + VAR_W'(1);
      lit.pol = ~best_idx[0];
    end
  end

endmodule
`default_nettype wire

// File: rtl/dlis_branch_decider.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : dlis_branch_decider                                             |
// | Purpose  : DLIS branching heuristic. On a find request the formula is      |
// |            snapshotted, scanned one clause per cycle into per-literal      |
// |            counters, and the most frequent literal is returned.            |
// | Ports    : clk, rst (async, active-high)                                   |
// |            bus (slave): find, in_formula -> ended, lit_out                 |
// | Config   : DB_MOMS_EN - count only clauses of minimal counted length.      |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module dlis_branch_decider
  import dlis_branch_decider_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  dlis_branch_decider_if.slave  bus
);

  state_t               state_q, state_d;
  formula_t             formula_q, formula_d;
  logic [NCL_W-1:0]     idx_q, idx_d;
  cnt_t [NUM_LITS-1:0]  cnt_q, cnt_d;
  logic                 ended_q, ended_d;
  lit_t                 lit_out_q, lit_out_d;
`ifdef DB_MOMS_EN
  logic [LEN_W-1:0]     min_len_q, min_len_d;
`endif

  logic [NCL_W-1:0]     ncl;
  clause_t              cur;
  logic [LEN_W-1:0]     len_eff;
  logic [MAX_LITS-1:0]  slot_ok;
  logic [LEN_W-1:0]     nlen;
  lit_t                 best_lit;

  db_argmax u_argmax (
    .cnt (cnt_q),
    .lit (best_lit)
  );

  // Decode of the clause under the scan pointer.
  always_comb begin
    ncl     = (formula_q.num_clauses > NCL_W'(MAX_CLAUSES)) ? NCL_W'(MAX_CLAUSES)
                                                             : formula_q.num_clauses;
    cur     = formula_q.clauses[idx_q];
    len_eff = (cur.len > LEN_W'(MAX_LITS)) ? LEN_W'(MAX_LITS) : cur.len;
    nlen    = '0;
    for (int j = 0; j < MAX_LITS; j++) begin
      // Slots past len or holding var 0 are padding.
      slot_ok[j] = (LEN_W'(j) < len_eff) && (cur.lits[j].vid != '0);
      nlen       = nlen + LEN_W'(slot_ok[j]);
    end
  end

  always_comb begin
    state_d   = state_q;
    formula_d = formula_q;
    idx_d     = idx_q;
    cnt_d     = cnt_q;
    ended_d   = ended_q;
    lit_out_d = lit_out_q;
`ifdef DB_MOMS_EN
    min_len_d = min_len_q;
`endif

    case (state_q)
      ST_IDLE: begin
        ended_d = 1'b0;
        if (bus.find) begin
          formula_d = bus.in_formula;
          cnt_d     = '0;
          idx_d     = '0;
`ifdef DB_MOMS_EN
          min_len_d = '1;
`endif
          state_d   = ST_SCAN;
        end
      end

      ST_SCAN: begin
        if (idx_q == ncl) begin
          state_d = ST_PICK;
        end else begin
          idx_d = idx_q + NCL_W'(1);
`ifdef DB_MOMS_EN
          // A strictly shorter clause restarts the tally; longer or empty
          // clauses are skipped entirely.
          if (nlen != '0 && nlen < min_len_q) begin
            cnt_d     = '0;
            min_len_d = nlen;
            for (int j = 0; j < MAX_LITS; j++)
              if (slot_ok[j])
                cnt_d[lit_index(cur.lits[j])] = cnt_d[lit_index(cur.lits[j])] + CNT_W'(1);
          end else if (nlen == min_len_q) begin
            for (int j = 0; j < MAX_LITS; j++)
              if (slot_ok[j])
                cnt_d[lit_index(cur.lits[j])] = cnt_d[lit_index(cur.lits[j])] + CNT_W'(1);
          end
`else
          for (int j = 0; j < MAX_LITS; j++)
            if (slot_ok[j])
              cnt_d[lit_index(cur.lits[j])] = cnt_d[lit_index(cur.lits[j])] + CNT_W'(1);
`endif
        end
      end

      ST_PICK: begin
        lit_out_d = best_lit;
        ended_d   = 1'b1;
        state_d   = ST_DONE;
      end

      ST_DONE: begin
        if (!bus.find) begin
          ended_d = 1'b0;
          state_d = ST_IDLE;
        end
      end

      default: begin
        ended_d = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      formula_q <= '0;
      idx_q     <= '0;
      cnt_q     <= '0;
      ended_q   <= 1'b0;
      lit_out_q <= ZERO_LIT;
`ifdef DB_MOMS_EN
      min_len_q <= '1;
`endif
    end else begin
      state_q   <= state_d;
      formula_q <= formula_d;
      idx_q     <= idx_d;
      cnt_q     <= cnt_d;
      ended_q   <= ended_d;
      lit_out_q <= lit_out_d;
`ifdef DB_MOMS_EN
      min_len_q <= min_len_d;
`endif
    end
  end

  assign bus.ended   = ended_q;
  assign bus.lit_out = lit_out_q;

endmodule
`default_nettype wire

// File: tb/tb_dlis_branch_decider.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_dlis_branch_decider                                          |
// | Purpose  : Directed table-driven bench for dlis_branch_decider, plus hand  |
// |            sequences for reset, snapshot, early find drop and abort.       |
// |            Expected values follow DB_MOMS_EN when it is defined.           |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module tb_dlis_branch_decider;
  import dlis_branch_decider_pkg::*;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  dlis_branch_decider_if bus ();

  dlis_branch_decider dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string    name;
    formula_t f;
    lit_t     exp_lit;
    int       exp_lat;
  } vec_t;

  vec_t vecs[7];

  function automatic lit_t pl(input int v);
    lit_t l;
    l.vid = VAR_W'(v);
    l.pol = 1'b1;
    return l;
  endfunction

  function automatic lit_t nl(input int v);
    lit_t l;
    l.vid = VAR_W'(v);
    l.pol = 1'b0;
    return l;
  endfunction

  function automatic clause_t mk(input int len, input lit_t a, input lit_t b,
                                 input lit_t c, input lit_t d, input lit_t e);
    clause_t cl;
    cl.len     = LEN_W'(len);
    cl.lits[0] = a;
    cl.lits[1] = b;
    cl.lits[2] = c;
    cl.lits[3] = d;
    cl.lits[4] = e;
    return cl;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual %0h required %0h", nm, act, exp);
    end
  endtask

  // Drives a request from a negedge and returns edges-after-k until ended, -1 on timeout.
  task automatic run_req(input formula_t f, output int lat);
    bus.in_formula = f;
    bus.find       = 1'b1;
    lat            = -1;
    for (int c = 1; c <= 40; c++) begin
      @(posedge clk);
      @(negedge clk);
      if (bus.ended) begin
        lat = c - 1;
        break;
      end
    end
  endtask

  formula_t fa;
  lit_t     exp_a;

  initial begin
    formula_t f;
    lit_t     z;
    int       lat;
    lit_t     prev;

    checks = 0;
    errors = 0;
    z      = ZERO_LIT;

    // Spec example formula
    fa = '0;
    fa.clauses[0] = mk(5, pl(5), pl(2), pl(3), pl(4), pl(1));
    fa.clauses[1] = mk(2, nl(2), nl(5), z, z, z);
    fa.clauses[2] = mk(3, nl(1), nl(2), nl(5), z, z);
    for (int i = 3; i <= 7; i++) fa.clauses[i] = mk(2, pl(1), pl(2), z, z, z);
    fa.clauses[8] = mk(3, nl(2), nl(3), pl(4), z, z);
    fa.clauses[9] = mk(1, nl(3), z, z, z, z);
    fa.num_clauses = 4'd10;
`ifdef DB_MOMS_EN
    exp_a = nl(3);
`else
    exp_a = pl(1);
`endif
    vecs[0] = '{name: "spec10", f: fa, exp_lit: exp_a, exp_lat: 12};

    f = fa;
    f.num_clauses = 4'd0;
    vecs[1] = '{name: "zero_cl", f: f, exp_lit: z, exp_lat: 2};

    f = '0;
    f.clauses[0] = mk(2, nl(4), pl(4), z, z, z);
    f.num_clauses = 4'd1;
    vecs[2] = '{name: "pos_tie", f: f, exp_lit: pl(4), exp_lat: 3};

    // Var-0 padding and slots beyond len must be ignored; -6/+7 tie -> var 6
    f = '0;
    f.clauses[0] = mk(3, z, nl(6), nl(6), z, z);
    f.clauses[1] = mk(2, pl(7), pl(7), nl(6), nl(6), nl(6));
    f.num_clauses = 4'd2;
    vecs[3] = '{name: "padding", f: f, exp_lit: nl(6), exp_lat: 4};

    f = '0;
    for (int i = 0; i < MAX_CLAUSES; i++) f.clauses[i] = mk(1, nl(7), z, z, z, z);
    f.num_clauses = 4'd15;
    vecs[4] = '{name: "ncl_clamp", f: f, exp_lit: nl(7), exp_lat: 12};

    f = '0;
    for (int i = 0; i < 3; i++) f.clauses[i] = mk(0, pl(1), pl(1), pl(1), pl(1), pl(1));
    f.num_clauses = 4'd3;
    vecs[5] = '{name: "all_empty", f: f, exp_lit: z, exp_lat: 5};

    // len 7 counts as 5
    f = '0;
    f.clauses[0] = mk(7, pl(3), pl(3), pl(3), pl(3), pl(3));
    f.clauses[1] = mk(4, nl(2), nl(2), nl(2), nl(2), z);
    f.num_clauses = 4'd2;
`ifdef DB_MOMS_EN
    vecs[6] = '{name: "len_clamp", f: f, exp_lit: nl(2), exp_lat: 4};
`else
    vecs[6] = '{name: "len_clamp", f: f, exp_lit: pl(3), exp_lat: 4};
`endif

    // Reset held 160 ns
    rst            = 1'b1;
    bus.find       = 1'b0;
    bus.in_formula = '0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      chk("rst_ended", 32'(bus.ended), 32'd0);
      chk("rst_lit", 32'(bus.lit_out), 32'd0);
    end
    rst = 1'b0;
    @(negedge clk);

    // Table-driven requests
    foreach (vecs[i]) begin
      run_req(vecs[i].f, lat);
      chk({vecs[i].name, "_lat"}, 32'(lat), 32'(vecs[i].exp_lat));
      chk({vecs[i].name, "_lit"}, 32'(bus.lit_out), 32'(vecs[i].exp_lit));
      @(posedge clk);
      @(negedge clk);
      chk({vecs[i].name, "_hold_ended"}, 32'(bus.ended), 32'd1);
      chk({vecs[i].name, "_hold_lit"}, 32'(bus.lit_out), 32'(vecs[i].exp_lit));
      bus.find = 1'b0;
      @(posedge clk);
      @(negedge clk);
      chk({vecs[i].name, "_idle_ended"}, 32'(bus.ended), 32'd0);
      chk({vecs[i].name, "_idle_lit"}, 32'(bus.lit_out), 32'(vecs[i].exp_lit));
      @(negedge clk);
    end
    prev = vecs[6].exp_lit;

    // Snapshot + find dropped during SCAN + lit_out holds previous result
    bus.in_formula = fa;
    bus.find       = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.in_formula = '0;
    bus.find       = 1'b0;
    chk("drop_hold_lit", 32'(bus.lit_out), 32'(prev));
    chk("drop_ended_low", 32'(bus.ended), 32'd0);
    lat = -1;
    for (int c = 1; c <= 40; c++) begin
      @(posedge clk);
      @(negedge clk);
      if (bus.ended) begin
        lat = c;
        break;
      end
    end
    chk("drop_lat", 32'(lat), 32'd12);
    chk("drop_lit", 32'(bus.lit_out), 32'(exp_a));
    @(posedge clk);
    @(negedge clk);
    chk("drop_one_cycle", 32'(bus.ended), 32'd0);
    chk("drop_lit_kept", 32'(bus.lit_out), 32'(exp_a));

    // Reset asserted mid-SCAN aborts immediately
    bus.in_formula = fa;
    bus.find       = 1'b1;
    repeat (4) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("abort_ended", 32'(bus.ended), 32'd0);
    chk("abort_lit", 32'(bus.lit_out), 32'd0);
    @(posedge clk);
    @(negedge clk);
    bus.find = 1'b0;
    rst      = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("abort_idle", 32'(bus.ended), 32'd0);
    run_req(vecs[2].f, lat);
    chk("fresh_lat", 32'(lat), 32'd3);
    chk("fresh_lit", 32'(bus.lit_out), 32'(pl(4)));
    bus.find = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("fresh_idle", 32'(bus.ended), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
